// File: rtl/usb2_ulpi_phy_emu.sv
// ULPI PHY emulator: decodes link TX_CMDs, hosts a small PHY register file,
// reports line/VBUS changes as RX_CMDs and injects receive packets onto the bus.
module usb2_ulpi_phy_emu #(
  parameter logic [15:0] VENDOR_ID    = 16'h0451,
  parameter logic [15:0] PRODUCT_ID   = 16'h1507,
  parameter int          RESET_CYCLES = 64
) (
  input  logic       phy_clk,
  input  logic       reset,
  input  logic [7:0] ulpi_d_in,
  output logic [7:0] ulpi_d_out,
  output logic       ulpi_dir,
  output logic       ulpi_d_oe,
  output logic       ulpi_nxt,
  input  logic       ulpi_stp,
  input  logic [1:0] line_state,
  input  logic [1:0] vbus_state,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       rx_last,
  output logic       rx_ready,
  output logic       tx_start,
  output logic [3:0] tx_pid,
  output logic       tx_valid,
  output logic [7:0] tx_byte,
  output logic       tx_end,
  output logic       tx_abort,
  output logic [7:0] reg_func_ctrl,
  output logic [7:0] reg_otg_ctrl
);

  // state    | meaning
  // IDLE     | link owns bus; arbitrate TX_CMD > packet > status change
  // CMD_ACK  | nxt acknowledges TX_CMD; extended-address commands park here
  // WR_DATA  | register write data byte; WR_STP waits for stp to commit
  // RD_TURN  | turnaround to PHY for read; RD_DATA drives register value
  // TX_DATA  | transmit payload until stp
  // RXC_TURN | turnaround for RX_CMD; RXC_DATA drives the RX_CMD byte
  // PKT_TURN | turnaround with nxt (receive start); PKT_DATA bytes; PKT_EOP final RX_CMD
  // RST_HOLD | PHY reset after Function Control Reset, bus held by PHY
  typedef enum logic [3:0] {
    IDLE, CMD_ACK, WR_DATA, WR_STP, RD_TURN, RD_DATA, TX_DATA,
    RXC_TURN, RXC_DATA, PKT_TURN, PKT_DATA, PKT_EOP, RST_HOLD
  } state_t;

  localparam int CW = $clog2(RESET_CYCLES + 1);

  state_t          state;
  logic [7:0]      cmd;
  logic [7:0]      wr_data;
  logic            ext_cmd;
  logic            pkt_done;
  logic [3:0]      last_status;
  logic [CW-1:0]   rst_cnt;
  logic [3:0]      status;
  logic [7:0]      rxcmd_idle;
  logic [7:0]      rxcmd_pkt;
  logic [7:0]      rd_value;

  assign status     = {vbus_state, line_state};
  assign rxcmd_idle = {4'b0000, status};
  assign rxcmd_pkt  = {2'b00, 2'b01, status};
  assign ulpi_d_oe  = ulpi_dir;

  // Handshake with the injector must be same-cycle, so this one is combinational.
  assign rx_ready = rx_valid &&
                    ((state == PKT_TURN) || ((state == PKT_DATA) && !pkt_done));

  always_comb begin
    rd_value = 8'h00;
    case (cmd[5:0])
      6'h00:   rd_value = VENDOR_ID[7:0];
      6'h01:   rd_value = VENDOR_ID[15:8];
      6'h02:   rd_value = PRODUCT_ID[7:0];
      6'h03:   rd_value = PRODUCT_ID[15:8];
      6'h04:   rd_value = reg_func_ctrl;
      6'h0A:   rd_value = reg_otg_ctrl;
      default: rd_value = 8'h00;
    endcase
  end

  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cmd           <= 8'h00;
      wr_data       <= 8'h00;
      ext_cmd       <= 1'b0;
      pkt_done      <= 1'b0;
      last_status   <= 4'h0;
      rst_cnt       <= '0;
      ulpi_d_out    <= 8'h00;
      ulpi_dir      <= 1'b0;
      ulpi_nxt      <= 1'b0;
      tx_start      <= 1'b0;
      tx_pid        <= 4'h0;
      tx_valid      <= 1'b0;
      tx_byte       <= 8'h00;
      tx_end        <= 1'b0;
      tx_abort      <= 1'b0;
      reg_func_ctrl <= 8'h41;
      reg_otg_ctrl  <= 8'h06;
    end else begin
      tx_start <= 1'b0;
      tx_valid <= 1'b0;
      tx_end   <= 1'b0;
      tx_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (ulpi_d_in != 8'h00) begin
            if (ulpi_d_in[7:6] != 2'b00) begin
              cmd   <= ulpi_d_in;
              state <= CMD_ACK;
              if (ulpi_d_in[7] && (ulpi_d_in[5:0] == 6'h2F)) begin
                ext_cmd  <= 1'b1;
                ulpi_nxt <= 1'b0;
              end else begin
                ext_cmd  <= 1'b0;
                ulpi_nxt <= 1'b1;
              end
              if (ulpi_d_in[7:6] == 2'b01) begin
                tx_start <= 1'b1;
                tx_pid   <= ulpi_d_in[3:0];
              end
            end
          end else if (rx_valid) begin
            ulpi_dir <= 1'b1;
            ulpi_nxt <= 1'b1;
            pkt_done <= 1'b0;
            state    <= PKT_TURN;
          end else if (status != last_status) begin
            ulpi_dir <= 1'b1;
            ulpi_nxt <= 1'b0;
            state    <= RXC_TURN;
          end
        end
        CMD_ACK: begin
          if (ext_cmd) begin
            if (ulpi_d_in == 8'h00) state <= IDLE;
          end else begin
            case (cmd[7:6])
              2'b01:   state <= TX_DATA;
              2'b10:   state <= WR_DATA;
              2'b11: begin
                ulpi_dir <= 1'b1;
                ulpi_nxt <= 1'b0;
                state    <= RD_TURN;
              end
              default: begin
                ulpi_nxt <= 1'b0;
                state    <= IDLE;
              end
            endcase
          end
        end
        TX_DATA: begin
          if (ulpi_stp) begin
            tx_end   <= 1'b1;
            tx_abort <= (ulpi_d_in == 8'hFF);
            ulpi_nxt <= 1'b0;
            state    <= IDLE;
          end else begin
            tx_byte  <= ulpi_d_in;
            tx_valid <= 1'b1;
          end
        end
        WR_DATA: begin
          wr_data  <= ulpi_d_in;
          ulpi_nxt <= 1'b0;
          state    <= WR_STP;
        end
        WR_STP: begin
          if (ulpi_stp) begin
            state <= IDLE;
            if (cmd[5:0] == 6'h04) begin
              reg_func_ctrl <= wr_data & 8'hDF;
              if (wr_data[5]) begin
                ulpi_dir   <= 1'b1;
                ulpi_d_out <= 8'h00;
                rst_cnt    <= CW'(RESET_CYCLES - 1);
                state      <= RST_HOLD;
              end
            end else if (cmd[5:0] == 6'h0A) begin
              reg_otg_ctrl <= wr_data;
            end
          end
        end
        RD_TURN: begin
          ulpi_d_out <= rd_value;
          state      <= RD_DATA;
        end
        RXC_TURN: begin
          ulpi_d_out  <= rxcmd_idle;
          last_status <= status;
          state       <= RXC_DATA;
        end
        RD_DATA, RXC_DATA, PKT_EOP: begin
          ulpi_dir   <= 1'b0;
          ulpi_d_out <= 8'h00;
          state      <= IDLE;
        end
        PKT_TURN, PKT_DATA: begin
          state <= PKT_DATA;
          if ((state == PKT_DATA) && pkt_done) begin
            ulpi_d_out <= rxcmd_idle;
            ulpi_nxt   <= 1'b0;
            state      <= PKT_EOP;
          end else if (rx_valid) begin
            ulpi_d_out <= rx_byte;
            ulpi_nxt   <= 1'b1;
            pkt_done   <= rx_last;
          end else begin
            ulpi_d_out <= rxcmd_pkt;
            ulpi_nxt   <= 1'b0;
          end
        end
        RST_HOLD: begin
          if (rst_cnt == '0) begin
            ulpi_d_out  <= rxcmd_idle;
            last_status <= status;
            state       <= RXC_DATA;
          end else begin
            rst_cnt <= rst_cnt - CW'(1);
          end
        end
        default: begin
          ulpi_dir <= 1'b0;
          ulpi_nxt <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb2_ulpi_phy_emu.sv
// Bench for usb2_ulpi_phy_emu: register vector table, directed bus sequences and
// randomized traffic checked against a transaction-level model.
`timescale 1ns/1ps
module tb_usb2_ulpi_phy_emu;
  localparam int RESET_CYCLES = 64;

  logic       phy_clk = 1'b0;
  logic       reset;
  logic [7:0] ulpi_d_in, ulpi_d_out;
  logic       ulpi_dir, ulpi_d_oe, ulpi_nxt, ulpi_stp;
  logic [1:0] line_state, vbus_state;
  logic       rx_valid, rx_last, rx_ready;
  logic [7:0] rx_byte;
  logic       tx_start, tx_valid, tx_end, tx_abort;
  logic [3:0] tx_pid;
  logic [7:0] tx_byte, reg_func_ctrl, reg_otg_ctrl;

  usb2_ulpi_phy_emu #(.RESET_CYCLES(RESET_CYCLES)) dut (
    .phy_clk(phy_clk), .reset(reset), .ulpi_d_in(ulpi_d_in), .ulpi_d_out(ulpi_d_out),
    .ulpi_dir(ulpi_dir), .ulpi_d_oe(ulpi_d_oe), .ulpi_nxt(ulpi_nxt), .ulpi_stp(ulpi_stp),
    .line_state(line_state), .vbus_state(vbus_state), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .rx_last(rx_last), .rx_ready(rx_ready), .tx_start(tx_start),
    .tx_pid(tx_pid), .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_end(tx_end),
    .tx_abort(tx_abort), .reg_func_ctrl(reg_func_ctrl), .reg_otg_ctrl(reg_otg_ctrl)
  );

  always #8 phy_clk = ~phy_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  int checks = 0;
  int failures = 0;

  logic       nx_rx_valid, nx_rx_last;
  logic [7:0] nx_rx_byte;
  logic [1:0] nx_line, nx_vbus;
  logic       s_dir, s_nxt, s_rdy;
  int         n_dir, n_nxt, n_rdy, n_start, n_end, oe_err;
  logic [3:0] last_pid;
  logic       last_abort;
  logic [7:0] dq[$];
  logic       nq[$];
  logic [7:0] txq[$];
  logic [7:0] pb[$];
  int         pg[$];
  logic [7:0] model_reg[64];
  logic [3:0] last_rep;

  typedef struct {
    logic       wr;
    logic [5:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dq_at(input int i);
    if (i >= 0 && i < dq.size()) return 32'(dq[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic clr();
    n_dir = 0; n_nxt = 0; n_rdy = 0; n_start = 0; n_end = 0;
    last_pid = 4'h0; last_abort = 1'b0;
    dq.delete(); nq.delete(); txq.delete();
  endtask

  // One bus cycle: drive after the rising edge, sample on the falling edge.
  task automatic step(input logic [7:0] d, input logic s);
    @(posedge phy_clk);
    #1;
    ulpi_d_in = d; ulpi_stp = s;
    rx_valid = nx_rx_valid; rx_byte = nx_rx_byte; rx_last = nx_rx_last;
    line_state = nx_line; vbus_state = nx_vbus;
    @(negedge phy_clk);
    s_dir = ulpi_dir; s_nxt = ulpi_nxt; s_rdy = rx_ready;
    if (ulpi_d_oe !== ulpi_dir) oe_err++;
    if (ulpi_dir) begin n_dir++; dq.push_back(ulpi_d_out); nq.push_back(ulpi_nxt); end
    if (ulpi_nxt) n_nxt++;
    if (rx_ready) n_rdy++;
    if (tx_start) begin n_start++; last_pid = tx_pid; end
    if (tx_valid) txq.push_back(tx_byte);
    if (tx_end) begin n_end++; last_abort = tx_abort; end
  endtask

  task automatic wait_ack(input logic [7:0] c, input string name);
    for (int k = 0; k < 8 && !s_nxt; k++) step(c, 1'b0);
    chk(name, s_nxt, 1'b1);
  endtask

  task automatic reg_write(input logic [5:0] a, input logic [7:0] d);
    logic [7:0] c;
    c = {2'b10, a};
    clr();
    step(c, 1'b0);
    wait_ack(c, "wr_ack");
    step(d, 1'b0);
    step(8'h00, 1'b1);
    for (int j = 0; j < 120; j++) begin
      step(8'h00, 1'b0);
      if (!s_dir && j >= 2) break;
    end
  endtask

  task automatic reg_read(input logic [5:0] a, output logic [7:0] v);
    logic [7:0] c;
    c = {2'b11, a};
    clr();
    step(c, 1'b0);
    wait_ack(c, "rd_ack");
    for (int j = 0; j < 10; j++) begin
      step(8'h00, 1'b0);
      if (!s_dir && j >= 1) break;
    end
    v = dq_at(dq.size() - 1);
  endtask

  function automatic void model_write(input logic [5:0] a, input logic [7:0] d);
    if (a == 6'h04) model_reg[4] = d & 8'hDF;
    else if (a == 6'h0A) model_reg[10] = d;
  endfunction

  function automatic void model_init();
    foreach (model_reg[i]) model_reg[i] = 8'h00;
    model_reg[0] = 8'h51; model_reg[1] = 8'h04; model_reg[2] = 8'h07; model_reg[3] = 8'h15;
    model_reg[4] = 8'h41; model_reg[10] = 8'h06;
  endfunction

  // Transmit pb[] with the given PID; endb is the byte on the stp cycle.
  task automatic tx_send(input logic [3:0] pid, input logic [7:0] endb);
    logic [7:0] c;
    int err;
    c = {4'h4, pid};
    clr();
    step(c, 1'b0);
    wait_ack(c, "tx_ack");
    foreach (pb[i]) step(pb[i], 1'b0);
    step(endb, 1'b1);
    repeat (3) step(8'h00, 1'b0);
    err = 0;
    for (int i = 0; i < pb.size() && i < txq.size(); i++) if (txq[i] !== pb[i]) err++;
    chk("tx_start_cnt", n_start, 1);
    chk("tx_pid", last_pid, pid);
    chk("tx_pid_held", tx_pid, pid);
    chk("tx_len", txq.size(), pb.size());
    chk("tx_bytes", err, 0);
    chk("tx_end_cnt", n_end, 1);
    chk("tx_abort", last_abort, (endb == 8'hFF));
  endtask

  // Inject pb[] with pg[i] idle cycles after byte i; compare bus stream to model.
  task automatic pkt_send();
    logic [7:0] ed[$];
    logic       en[$];
    logic [7:0] st;
    int idx, gap, n, err;
    n = pb.size();
    st = {4'b0000, nx_vbus, nx_line};
    ed.push_back(8'h00); en.push_back(1'b1);
    for (int i = 0; i < n; i++) begin
      ed.push_back(pb[i]); en.push_back(1'b1);
      if (i < n - 1) for (int g = 0; g < pg[i]; g++) begin
        ed.push_back(st | 8'h10); en.push_back(1'b0);
      end
    end
    ed.push_back(st); en.push_back(1'b0);
    clr();
    idx = 0; gap = 0;
    for (int c = 0; c < 80; c++) begin
      nx_rx_valid = (idx < n) && (gap == 0);
      nx_rx_byte  = (idx < n) ? pb[idx] : 8'h00;
      nx_rx_last  = (idx == n - 1);
      if (gap > 0) gap--;
      step(8'h00, 1'b0);
      if (s_rdy) begin
        idx++;
        if (idx < n) gap = pg[idx - 1];
      end
      if (idx == n && !s_dir) break;
    end
    nx_rx_valid = 1'b0; nx_rx_last = 1'b0;
    err = 0;
    for (int i = 0; i < ed.size() && i < dq.size(); i++) begin
      if (nq[i] !== en[i]) err++;
      if (i > 0 && dq[i] !== ed[i]) err++;
    end
    chk("pkt_len", dq.size(), ed.size());
    chk("pkt_stream", err, 0);
    chk("pkt_ready_cnt", n_rdy, n);
  endtask

  initial begin
    logic [7:0] v;
    logic [5:0] a;
    logic [7:0] d;
    logic [3:0] ns;

    reset = 1'b1;
    ulpi_d_in = 8'h00; ulpi_stp = 1'b0; line_state = 2'b00; vbus_state = 2'b00;
    rx_valid = 1'b0; rx_byte = 8'h00; rx_last = 1'b0;
    nx_rx_valid = 1'b0; nx_rx_byte = 8'h00; nx_rx_last = 1'b0; nx_line = 2'b00; nx_vbus = 2'b00;
    s_dir = 1'b0; s_nxt = 1'b0; s_rdy = 1'b0; oe_err = 0;
    last_rep = 4'h0;
    clr();
    model_init();
    #20;
    chk("rst_dir", ulpi_dir, 1'b0);
    chk("rst_nxt", ulpi_nxt, 1'b0);
    chk("rst_dout", ulpi_d_out, 8'h00);
    chk("rst_tx", {tx_start, tx_valid, tx_end, tx_abort, tx_pid}, 8'h00);
    chk("rst_func_ctrl", reg_func_ctrl, 8'h41);
    chk("rst_otg_ctrl", reg_otg_ctrl, 8'h06);
    @(posedge phy_clk); #1 reset = 1'b0;
    repeat (3) step(8'h00, 1'b0);
    chk("idle_no_dir", n_dir, 0);

    tbl[0]  = '{1'b0, 6'h00, 8'h00, 8'h51};
    tbl[1]  = '{1'b0, 6'h01, 8'h00, 8'h04};
    tbl[2]  = '{1'b0, 6'h02, 8'h00, 8'h07};
    tbl[3]  = '{1'b0, 6'h03, 8'h00, 8'h15};
    tbl[4]  = '{1'b0, 6'h04, 8'h00, 8'h41};
    tbl[5]  = '{1'b0, 6'h0A, 8'h00, 8'h06};
    tbl[6]  = '{1'b0, 6'h16, 8'h00, 8'h00};
    tbl[7]  = '{1'b1, 6'h04, 8'h55, 8'h00};
    tbl[8]  = '{1'b0, 6'h04, 8'h00, 8'h55};
    tbl[9]  = '{1'b1, 6'h0A, 8'hA5, 8'h00};
    tbl[10] = '{1'b0, 6'h0A, 8'h00, 8'hA5};
    tbl[11] = '{1'b1, 6'h07, 8'hFF, 8'h00};
    tbl[12] = '{1'b0, 6'h07, 8'h00, 8'h00};
    tbl[13] = '{1'b1, 6'h05, 8'h12, 8'h00};
    tbl[14] = '{1'b0, 6'h04, 8'h00, 8'h55};
    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        reg_write(tbl[i].addr, tbl[i].data);
        model_write(tbl[i].addr, tbl[i].data);
        chk($sformatf("tbl%0d_wr_nxt", i), n_nxt, 2);
        chk($sformatf("tbl%0d_wr_dir", i), n_dir, 0);
      end else begin
        reg_read(tbl[i].addr, v);
        chk($sformatf("tbl%0d_rd_val", i), v, tbl[i].exp);
        chk($sformatf("tbl%0d_rd_dir", i), n_dir, 2);
      end
    end
    chk("func_ctrl_port", reg_func_ctrl, 8'h55);
    chk("otg_ctrl_port", reg_otg_ctrl, 8'hA5);

    // status change: line 00->01 with VBUS valid
    nx_vbus = 2'b11; nx_line = 2'b01;
    clr();
    repeat (6) step(8'h00, 1'b0);
    chk("rxcmd_dir", n_dir, 2);
    chk("rxcmd_val", dq_at(1), 8'h0D);
    chk("rxcmd_nxt", n_nxt, 0);
    last_rep = 4'hD;
    clr();
    repeat (6) step(8'h00, 1'b0);
    chk("rxcmd_no_repeat", n_dir, 0);

    // Function Control reset bit
    reg_write(6'h04, 8'h65);
    model_write(6'h04, 8'h65);
    chk("rsthold_dir", n_dir, RESET_CYCLES + 1);
    chk("rsthold_nxt", n_nxt, 2);
    chk("rsthold_rxcmd", dq_at(dq.size() - 1), 8'h0D);
    chk("rsthold_func", reg_func_ctrl, 8'h45);

    // extended address: never acknowledged
    clr();
    repeat (4) step(8'hAF, 1'b0);
    repeat (2) step(8'h00, 1'b0);
    chk("ext_nxt", n_nxt, 0);
    chk("ext_dir", n_dir, 0);
    reg_read(6'h0A, v);
    chk("after_ext_rd", v, 8'hA5);

    pb.delete(); pb.push_back(8'h11); pb.push_back(8'h22);
    tx_send(4'h3, 8'h00);
    pb.delete(); pb.push_back(8'h5A);
    tx_send(4'hA, 8'hFF);

    pb.delete(); pg.delete();
    pb.push_back(8'hC3); pb.push_back(8'h01); pb.push_back(8'h02);
    pg.push_back(1); pg.push_back(0);
    pkt_send();
    chk("pkt_turn_nxt", (nq.size() > 0) ? nq[0] : 1'b0, 1'b1);
    chk("pkt_gap_bit4", dq_at(2) & 32'h10, 32'h10);
    chk("pkt_eop_bit4", dq_at(dq.size() - 1) & 32'h10, 32'h00);

    // randomized register traffic
    for (int it = 0; it < 20; it++) begin
      a = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 2))
        0: a = 6'h04;
        1: a = 6'h0A;
        default: if (a == 6'h2F) a = 6'h0A;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom);
        if (a == 6'h04 && $urandom_range(0, 3) != 0) d[5] = 1'b0;
        reg_write(a, d);
        chk("rnd_wr_dir", n_dir, (a == 6'h04 && d[5]) ? RESET_CYCLES + 1 : 0);
        model_write(a, d);
        chk("rnd_func_port", reg_func_ctrl, model_reg[4]);
        chk("rnd_otg_port", reg_otg_ctrl, model_reg[10]);
      end else begin
        reg_read(a, v);
        chk($sformatf("rnd_rd_%0h", a), v, model_reg[a]);
      end
    end

    // randomized status changes
    for (int it = 0; it < 12; it++) begin
      ns = 4'($urandom);
      nx_vbus = ns[3:2]; nx_line = ns[1:0];
      clr();
      repeat (6) step(8'h00, 1'b0);
      chk("rnd_rxcmd_dir", n_dir, (ns != last_rep) ? 2 : 0);
      if (ns != last_rep) chk("rnd_rxcmd_val", dq_at(1), {4'h0, ns});
      last_rep = ns;
    end

    // randomized transmit packets
    for (int it = 0; it < 8; it++) begin
      pb.delete();
      for (int i = 0; i < int'($urandom_range(0, 5)); i++) pb.push_back(8'($urandom));
      tx_send(4'($urandom), ($urandom_range(0, 3) == 0) ? 8'hFF : 8'h00);
    end

    // randomized receive packets
    for (int it = 0; it < 6; it++) begin
      pb.delete(); pg.delete();
      for (int i = 0; i < int'($urandom_range(1, 5)); i++) begin
        pb.push_back(8'($urandom));
        pg.push_back(int'($urandom_range(0, 2)));
      end
      pkt_send();
    end

    // async reset in the middle of a register read
    nx_vbus = 2'b11; nx_line = 2'b01;
    repeat (6) step(8'h00, 1'b0);
    clr();
    step(8'hC4, 1'b0);
    wait_ack(8'hC4, "arst_rd_ack");
    step(8'h00, 1'b0);
    chk("arst_pre_dir", s_dir, 1'b1);
    #3 reset = 1'b1;
    #1;
    chk("arst_dir", ulpi_dir, 1'b0);
    chk("arst_nxt", ulpi_nxt, 1'b0);
    chk("arst_func", reg_func_ctrl, 8'h41);
    @(posedge phy_clk); #2 reset = 1'b0;
    model_init();
    clr();
    repeat (6) step(8'h00, 1'b0);
    chk("arst_rxcmd_dir", n_dir, 2);
    chk("arst_rxcmd_val", dq_at(1), 8'h0D);
    reg_read(6'h04, v);
    chk("arst_rd_func", v, model_reg[4]);
    chk("oe_eq_dir", oe_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
